// File: rtl/cache_refill_arbiter_pkg.sv
// Shared constants and types for the cache refill arbiter slice.
// Provides AXI burst encodings, requester ids and the refill FSM state type.
package cache_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

  localparam logic [3:0] REQ_ID_I = 4'd0;
  localparam logic [3:0] REQ_ID_D = 4'd1;

  localparam int DEFAULT_BLOCK_SIZE = 5;

  // Number of 32-bit beats in a block of 2**block_size bytes.
  function automatic int beats(input int block_size);
    return 1 << (block_size - 2);
  endfunction

  localparam int BEATS = beats(DEFAULT_BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// AXI read-channel (AR + R) bundle between the refill arbiter and the top-level AXI port.
// The arbiter uses the master modport; the memory side uses the slave modport.
interface cache_refill_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [3:0]            arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );

endinterface

// File: rtl/cache_refill_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; bit 0 is the icache, bit 1 the dcache.
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner only when the grant is actually taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one AXI read channel between icache and dcache block refills, one burst at a time.
// Define CRITICAL_WORD_FIRST_EN for WRAP bursts starting at the missed word; default is INCR from word 0.
module cache_refill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_rvalid,
  output logic                  d_done,
  output logic [BLOCK_SIZE-3:0] r_word,
  output logic [DATA_WIDTH-1:0] r_data,
  cache_refill_arbiter_if.master axi
);

  localparam int         WORD_W = BLOCK_SIZE - 2;
  localparam logic [7:0] AR_LEN = 8'(beats(BLOCK_SIZE) - 1);

  state_t                state, state_nxt;
  logic [1:0]            grant;
  logic                  grant_en;
  logic                  ar_fire;
  logic                  beat_fire;
  logic                  rready_c;
  logic                  done_any;
  logic                  serve_d;
  logic                  arvalid_q;
  logic [3:0]            arid_q;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [ADDR_WIDTH-1:0] ar_addr_c;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [WORD_W-1:0]     start_word;
  logic [WORD_W-1:0]     beat_idx;
  logic                  unused_rid;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({d_req, i_req}),
    .update (grant_en),
    .grant  (grant)
  );

  assign miss_addr = grant[1] ? d_addr : i_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(3);
  localparam logic [1:0]            BURST_TYPE = AXI_BURST_WRAP;
  assign start_word = miss_addr[BLOCK_SIZE-1:2];
`else
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << BLOCK_SIZE) - 64'd1);
  localparam logic [1:0]            BURST_TYPE = AXI_BURST_INCR;
  assign start_word = '0;
`endif

  assign ar_addr_c  = miss_addr & ~ALIGN_MASK;
  assign done_any   = i_done | d_done;
  assign unused_rid = ^axi.rid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The done cycle stays in R with rready low so the served requester can drop req before IDLE samples.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    ar_fire   = 1'b0;
    beat_fire = 1'b0;
    rready_c  = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          grant_en  = 1'b1;
          state_nxt = AR;
        end
      end
      AR: begin
        if (arvalid_q && axi.arready) begin
          ar_fire   = 1'b1;
          state_nxt = R;
        end
      end
      R: begin
        if (done_any) begin
          state_nxt = IDLE;
        end else begin
          rready_c  = 1'b1;
          beat_fire = axi.rvalid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address phase and per-beat outputs; rlast alone decides when the burst ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      serve_d   <= 1'b0;
      beat_idx  <= '0;
      i_rvalid  <= 1'b0;
      i_done    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_done    <= 1'b0;
      r_word    <= '0;
      r_data    <= '0;
    end else begin
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
      if (grant_en) begin
        arvalid_q <= 1'b1;
        arid_q    <= grant[1] ? REQ_ID_D : REQ_ID_I;
        araddr_q  <= ar_addr_c;
        serve_d   <= grant[1];
        beat_idx  <= start_word;
      end
      if (ar_fire) begin
        arvalid_q <= 1'b0;
      end
      if (beat_fire) begin
        r_data   <= axi.rdata;
        r_word   <= beat_idx;
        beat_idx <= beat_idx + 1'b1;
        i_rvalid <= ~serve_d;
        d_rvalid <= serve_d;
        if (axi.rlast) begin
          i_done <= ~serve_d;
          d_done <= serve_d;
        end
      end
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = AR_LEN;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = BURST_TYPE;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_c;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter: directed vector table, hand sequences and a randomized run.
// Honours CRITICAL_WORD_FIRST_EN the same way as the design build.
module tb_cache_refill_arbiter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_rvalid, i_done, d_rvalid, d_done;
  logic [2:0]  r_word;
  logic [31:0] r_data;

  cache_refill_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_refill_arbiter #(.ADDR_WIDTH(32), .BLOCK_SIZE(5), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_rvalid (d_rvalid),
    .d_done   (d_done),
    .r_word   (r_word),
    .r_data   (r_data),
    .axi      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iq;
    bit          dq;
    logic [31:0] ia;
    logic [31:0] da;
    int          arWait;
    int          nBeats;
    bit          useFixed;
    logic [3:0]  expFirst;
    logic [3:0]  expSecond;
  } vec_t;

  vec_t        vecs[6];
  int          nTests = 0;
  int          nFail = 0;
  int          fixedGaps[10] = '{0, 2, 0, 4, 1, 0, 3, 0, 0, 0};
  bit          lastServedD;
  bit          curD;
  logic [31:0] curAddr;
  bit          pendI, pendD;
  int          iCount, dCount;

  // Reference model: what the AR channel and beat indices must look like for a miss address.
  function automatic logic [31:0] expAraddr(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a & ~32'h3;
`else
    return a & ~32'h1F;
`endif
  endfunction

  function automatic logic [2:0] expStart(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a[4:2];
`else
    return 3'd0;
`endif
  endfunction

  function automatic logic [1:0] expBurst();
`ifdef CRITICAL_WORD_FIRST_EN
    return 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  function automatic bit modelPickD();
    if (pendI && pendD) return !lastServedD;
    return pendD;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {bus.arvalid, bus.rready, i_rvalid, i_done, d_rvalid, d_done}, 0);
    checkOutput({tag, "_araddr"}, bus.araddr, 0);
    checkOutput({tag, "_arid"}, bus.arid, 0);
    checkOutput({tag, "_rword"}, r_word, 0);
    checkOutput({tag, "_rdata"}, r_data, 0);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rlast = 1'b0;
    bus.rdata = '0;
    bus.rid = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    resetn = 1'b1;
    lastServedD = 1'b0;
    @(negedge clk);
  endtask

  task automatic snapshot();
    pendI = i_req;
    pendD = d_req;
  endtask

  task automatic raisePending(input bit forceOne);
    if (!i_req && $urandom_range(0, 1) == 1) begin
      i_addr = $urandom;
      i_req = 1'b1;
    end
    if (!d_req && $urandom_range(0, 1) == 1) begin
      d_addr = $urandom;
      d_req = 1'b1;
    end
    if (forceOne && !i_req && !d_req) begin
      if ($urandom_range(0, 1) == 1) begin
        d_addr = $urandom;
        d_req = 1'b1;
      end else begin
        i_addr = $urandom;
        i_req = 1'b1;
      end
    end
  endtask

  // Raise the requester not currently being served, to exercise pending grants.
  task automatic maybeRaise(input bit randRaise);
    if (randRaise && $urandom_range(0, 2) == 0) begin
      if (curD && !i_req) begin
        i_addr = $urandom;
        i_req = 1'b1;
      end else if (!curD && !d_req) begin
        d_addr = $urandom;
        d_req = 1'b1;
      end
    end
  endtask

  task automatic expectGrant(input string tag, input logic [3:0] expId, input int expLat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.arvalid !== 1'b1 && lat < 30);
    if (bus.arvalid !== 1'b1) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL %s_grant_timeout: arvalid=%b after %0d cycles, expected 1", tag, bus.arvalid, lat);
      finishRun();
    end
    checkOutput({tag, "_grant_latency"}, lat, expLat);
    checkOutput({tag, "_arid"}, bus.arid, expId);
    curD = (expId == REQ_ID_D);
    curAddr = curD ? d_addr : i_addr;
    checkOutput({tag, "_araddr"}, bus.araddr, expAraddr(curAddr));
    checkOutput({tag, "_arlen"}, bus.arlen, 7);
    checkOutput({tag, "_arsize"}, bus.arsize, 2);
    checkOutput({tag, "_arburst"}, bus.arburst, expBurst());
  endtask

  task automatic serveBurst(input string tag, input int arWait, input int nBeats,
                            input bit useFixed, input bit randRaise, input int abortAfter);
    logic [31:0] data;
    logic [2:0]  start;
    logic [2:0]  expWord;
    start = expStart(curAddr);
    for (int w = 0; w < arWait; w++) begin
      bus.arready = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_arvalid_hold"}, bus.arvalid, 1);
      checkOutput({tag, "_araddr_hold"}, bus.araddr, expAraddr(curAddr));
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    checkOutput({tag, "_ar_single"}, bus.arvalid, 0);
    for (int b = 0; b < nBeats; b++) begin
      int gap;
      bit last;
      gap = useFixed ? fixedGaps[b % 10] : int'($urandom_range(0, 2));
      last = (b == nBeats - 1);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        maybeRaise(randRaise);
        checkOutput({tag, "_quiet"}, {i_rvalid, i_done, d_rvalid, d_done}, 0);
      end
      checkOutput({tag, "_rready"}, bus.rready, 1);
      data = $urandom;
      bus.rvalid = 1'b1;
      bus.rdata = data;
      bus.rlast = last;
      bus.rid = 4'($urandom);
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rlast = 1'b0;
      expWord = start + 3'(b);
      checkOutput({tag, "_beat_pulse"}, {i_rvalid, d_rvalid}, curD ? 2'b01 : 2'b10);
      checkOutput({tag, "_r_word"}, r_word, expWord);
      checkOutput({tag, "_r_data"}, r_data, data);
      checkOutput({tag, "_done"}, {i_done, d_done}, last ? (curD ? 2'b01 : 2'b10) : 2'b00);
      if (abortAfter > 0 && b + 1 == abortAfter) return;
      if (last) begin
        if (curD) d_req = 1'b0;
        else i_req = 1'b0;
        lastServedD = curD;
      end
      maybeRaise(randRaise);
    end
  endtask

  task automatic idleCycle(input string tag, input bit randRaise);
    @(negedge clk);
    checkOutput({tag, "_idle_gap"}, {bus.arvalid, i_rvalid, i_done, d_rvalid, d_done}, 0);
    if (randRaise) raisePending(1'b1);
    snapshot();
  endtask

  task automatic applyStimulus(input int k, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", k);
    doReset();
    i_addr = v.ia;
    d_addr = v.da;
    i_req = v.iq;
    d_req = v.dq;
    snapshot();
    expectGrant(tag, v.expFirst, 1);
    serveBurst(tag, v.arWait, v.nBeats, v.useFixed, 1'b0, 0);
    if (v.iq && v.dq) begin
      idleCycle(tag, 1'b0);
      expectGrant({tag, "_second"}, v.expSecond, 1);
      serveBurst({tag, "_second"}, v.arWait, v.nBeats, v.useFixed, 1'b0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    nTests++;
    nFail++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    finishRun();
  end

  initial begin
    i_addr = '0;
    d_addr = '0;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0, 0, 8, 1'b0, REQ_ID_I, REQ_ID_I};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_00FC, 2, 8, 1'b1, REQ_ID_D, REQ_ID_D};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_4008, 32'h0001_0010, 5, 8, 1'b0, REQ_ID_D, REQ_ID_I};
    vecs[3] = '{1'b1, 1'b0, 32'hDEAD_BEEC, 32'h0, 1, 5, 1'b0, REQ_ID_I, REQ_ID_I};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h0000_0F1C, 0, 11, 1'b1, REQ_ID_D, REQ_ID_D};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0012, 32'h7FFF_FFE4, 3, 8, 1'b0, REQ_ID_D, REQ_ID_I};

    for (int k = 0; k < 6; k++) applyStimulus(k, vecs[k]);

    // Tie rotation: dcache, then icache, then the next tie goes to dcache again.
    doReset();
    i_addr = 32'h0000_0040;
    d_addr = 32'h0000_0080;
    i_req = 1'b1;
    d_req = 1'b1;
    snapshot();
    expectGrant("tie1", REQ_ID_D, 1);
    serveBurst("tie1", 0, 8, 1'b0, 1'b0, 0);
    idleCycle("tie2", 1'b0);
    expectGrant("tie2", REQ_ID_I, 1);
    serveBurst("tie2", 0, 8, 1'b0, 1'b0, 0);
    @(negedge clk);
    checkOutput("tie3_idle_gap", bus.arvalid, 0);
    i_req = 1'b1;
    d_req = 1'b1;
    snapshot();
    expectGrant("tie3", REQ_ID_D, 1);
    serveBurst("tie3", 1, 8, 1'b0, 1'b0, 0);
    idleCycle("tie4", 1'b0);
    expectGrant("tie4", REQ_ID_I, 1);
    serveBurst("tie4", 0, 8, 1'b0, 1'b0, 0);

    // Reset in the middle of a dcache burst, then a fresh dcache refill.
    doReset();
    d_addr = 32'h0000_2044;
    d_req = 1'b1;
    snapshot();
    expectGrant("rstmid", REQ_ID_D, 1);
    serveBurst("rstmid", 1, 8, 1'b0, 1'b0, 3);
    #2 resetn = 1'b0;
    #1 checkAllZero("rstmid_async");
    @(negedge clk);
    checkOutput("rstmid_no_done", {i_done, d_done}, 0);
    resetn = 1'b1;
    lastServedD = 1'b0;
    snapshot();
    expectGrant("rstmid_again", REQ_ID_D, 1);
    serveBurst("rstmid_again", 0, 8, 1'b1, 1'b0, 0);

    // Randomized traffic against the arbitration and beat model.
    doReset();
    iCount = 0;
    dCount = 0;
    raisePending(1'b1);
    snapshot();
    for (int t = 0; t < 100; t++) begin
      bit pickD;
      int nb;
      pickD = modelPickD();
      if (pickD) dCount++;
      else iCount++;
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 11)) : 8;
      expectGrant("rand", pickD ? REQ_ID_D : REQ_ID_I, 1);
      serveBurst("rand", int'($urandom_range(0, 3)), nb, 1'b0, 1'b1, 0);
      idleCycle("rand", 1'b1);
    end
    checkOutput("rand_both_served", (iCount > 0) && (dCount > 0), 1);

    finishRun();
  end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Shares the single AXI read channel between the icache and dcache refill engines.
- Accepts one block-refill request per requester, grants one at a time (round-robin on ties), issues one AXI burst read and streams each returned word back to the granted cache with its word index.
- Sits between the cache arrays' miss logic and the top-level AXI interface.
- One outstanding transaction; read channel only (writeback is out of scope).

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- BLOCK_SIZE, 5, log2 bytes per cache block (32 B = 8 words).
- DATA_WIDTH, 32, AXI data width; fixed at 32, the only supported value.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  icache refill request; held with i_addr stable until i_done.
- i_addr  in  ADDR_WIDTH  icache miss address.
- i_rvalid  out  1  one-cycle pulse per returned word for icache.
- i_done  out  1  one-cycle pulse with the last icache word.
- d_req  in  1  dcache refill request.
- d_addr  in  ADDR_WIDTH  dcache miss address.
- d_rvalid  out  1  per-word pulse for dcache.
- d_done  out  1  last-word pulse for dcache.
- r_word  out  BLOCK_SIZE-2  word index within the block of the current beat (shared).
- r_data  out  DATA_WIDTH  beat data (shared).
- arid  out  4  0 = icache, 1 = dcache.
- araddr  out  ADDR_WIDTH  burst start address.
- arlen  out  8  beats-1, i.e. 7.
- arsize  out  3  2 (4 bytes).
- arburst  out  2  burst type.
- arvalid  out  1  address valid.
- arready  in  1  address ready.
- rid  in  4  response id (ignored).
- rdata  in  DATA_WIDTH  read data.
- rlast  in  1  last beat.
- rvalid  in  1  read valid.
- rready  out  1  read ready.

Behaviour:
- Reset (asynchronous, resetn low): state IDLE; all outputs 0 (arvalid, rready, *_rvalid, *_done, araddr, arid, r_word, r_data). last_grant=icache, so the first tie goes to dcache.
- States: IDLE -> AR -> R -> IDLE.
- IDLE:
  - Only d_req: grant dcache. Only i_req: grant icache.
  - Both: grant the requester that is not last_grant.
  - On grant: latch the address and id, set arvalid=1 on the next cycle, go to AR, update last_grant.
  - No request: stay in IDLE.
- AR:
  - Hold arvalid and all ar* stable until arvalid&&arready.
  - Then drop arvalid, go to R with rready=1 in the same cycle.
  - arlen=7, arsize=2. arburst and araddr are defined under Optional Feature.
- R:
  - rready=1.
  - Each cycle with rvalid: drive r_data=rdata and r_word=beat index, and pulse the granted requester's *_rvalid for exactly one cycle, registered (one-cycle latency after the beat).
  - The beat index starts at start_word and increments mod 2^(BLOCK_SIZE-2).
  - On rvalid&&rlast: pulse *_done together with the final *_rvalid, go to IDLE.
  - rlast is authoritative. If rlast arrives early, done is still issued on rlast. If more beats arrive than expected, the index wraps.
- Requester handshake:
  - The requester must drop req in the cycle after *_done.
  - The arbiter does not re-sample in the cycle *_done is asserted; IDLE is entered on the next cycle.
  - A req still high one cycle after done counts as a new request.
- A request arriving while the other requester is being served is held pending and granted in the next IDLE cycle. Back-to-back grants are therefore separated by exactly one IDLE cycle.
- A req dropped before grant is not required to be supported. The requester must keep req high until done.
- Reset mid-burst: return to IDLE immediately; no *_done is issued; the slave is assumed to reset together with this block.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - arburst=2'b10 (WRAP).
  - araddr = miss address with the low 2 bits cleared.
  - start_word = addr[BLOCK_SIZE-1:2], so the critical word returns first.
- Undefined:
  - arburst=2'b01 (INCR).
  - araddr = miss address with the low BLOCK_SIZE bits cleared.
  - start_word = 0.

Decomposition:
- Package cache_pkg:
  - AXI_BURST_INCR/AXI_BURST_WRAP constants.
  - BEATS = 2^(BLOCK_SIZE-2).
  - REQ_ID_I/REQ_ID_D.
  - State enum {IDLE, AR, R}.
- Sub-module rr_arbiter2: two-input round-robin arbiter with a last_grant register and an update enable.

Test Plan:
- Reset then only i_req with i_addr=0x0000_1234 -> arid=0; araddr=0x1220; arburst=01 (0x1234, arburst=10 with CWF); 8 i_rvalid pulses with r_word 0..7 (CWF: 5,6,7,0..4); i_done with the 8th.
- i_req and d_req rise in the same cycle after reset -> dcache served first; icache is granted in the first IDLE cycle after d_done; the next tie goes to dcache.
- arready held low 5 cycles -> arvalid/araddr stable for all 5 cycles; single handshake.
- rvalid gaps (beats on cycles 0, 3, 4, 9...) -> one *_rvalid pulse per beat, no duplicates; r_data matches rdata.
- resetn dropped after beat 3 of a dcache burst -> outputs 0 asynchronously; no d_done; after release a new d_req is re-served normally.
- d_req re-asserted during icache service -> granted immediately after i_done; no starvation over 100 alternating requests.
